// File: rtl/seq_detect.sv
// ---------------------------------------------------------------------------
// seq_detect
//
// Serial pattern detector fed by the serial code generator's MSB-first
// stream.  Every valid bit is shifted into a PAT_W-bit window; whenever the
// window equals PAT (and enough bits have arrived since the last restart)
// a one-cycle match pulse is produced and a saturating counter advances.
//
// Parameters:
//   PAT_W   - pattern length in bits (2..8)
//   PAT     - pattern to detect, MSB is the earliest-received bit
//   OVERLAP - 1: matches may share bits; 0: history restarts after a match
//   CNT_W   - width of the match counter
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset (highest priority)
//   bit_in    - serial data bit
//   bit_vld   - bit_in is sampled on this edge
//   clr       - synchronous clear of window, fill, match and counter
//   match     - one-cycle registered detection pulse
//   match_cnt - saturating count of detections
//   win       - last PAT_W sampled bits, win[0] newest
//   fill      - number of valid bits in the window, saturating at PAT_W
// ---------------------------------------------------------------------------
module seq_detect #(
  parameter int             PAT_W   = 5,
  parameter logic [PAT_W-1:0] PAT   = 5'b10110,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PAT_W-1:0] win,
  output logic [3:0]       fill
);

  localparam logic [3:0] FILL_MAX = 4'(PAT_W);
  localparam logic [3:0] FILL_THR = 4'(PAT_W - 1);

  logic [PAT_W-1:0] nxt;
  logic             hit;
  logic             cnt_full;

  // Window value after this edge's shift, and the detection condition.
  // fill must already hold PAT_W-1 bits so the incoming bit completes a
  // window made only of bits received since the last restart.
  always_comb begin
    nxt      = {win[PAT_W-2:0], bit_in};
    hit      = bit_vld && (fill >= FILL_THR) && (nxt == PAT);
    cnt_full = &match_cnt;
  end

  // Register stage: reset and clr clear everything and drop any bit
  // presented alongside them; otherwise match follows hit every edge and
  // the window/fill/count only move on valid bits.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      match     <= 1'b0;
      match_cnt <= '0;
      win       <= '0;
      fill      <= 4'd0;
    end else begin
      match <= hit;
      if (bit_vld) begin
        win <= nxt;
        if (hit && !OVERLAP) begin
          fill <= 4'd0;
        end else if (fill < FILL_MAX) begin
          fill <= fill + 4'd1;
        end
      end
      if (hit && !cnt_full) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect.sv
// ---------------------------------------------------------------------------
// tb_seq_detect
//
// Drives two seq_detect instances (overlapping and non-overlapping) with the
// same stimulus and compares every output after every edge against a
// reference built from the bit history kept in a queue.
// ---------------------------------------------------------------------------
module tb_seq_detect;

  localparam int             PAT_W = 5;
  localparam logic [PAT_W-1:0] PAT = 5'b10110;
  localparam int             CNT_W = 8;
  localparam int             CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, bit_in, bit_vld, clr;
  logic             match1, match0;
  logic [CNT_W-1:0] cnt1, cnt0;
  logic [PAT_W-1:0] win1, win0;
  logic [3:0]       fill1, fill0;

  int vectors = 0;
  int miscompares = 0;

  // reference state
  bit hist[$];
  int run1, run0;
  int expCnt1, expCnt0;
  bit expMatch1, expMatch0;

  seq_detect #(.PAT_W(PAT_W), .PAT(PAT), .OVERLAP(1'b1), .CNT_W(CNT_W)) dutOvl (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .clr(clr),
    .match(match1), .match_cnt(cnt1), .win(win1), .fill(fill1)
  );

  seq_detect #(.PAT_W(PAT_W), .PAT(PAT), .OVERLAP(1'b0), .CNT_W(CNT_W)) dutNoOvl (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .clr(clr),
    .match(match0), .match_cnt(cnt0), .win(win0), .fill(fill0)
  );

  always #5 clk = ~clk;

  // Last PAT_W received bits packed oldest-first; missing bits read as 0.
  function automatic int windowValue();
    int v = 0;
    foreach (hist[i]) v = (v << 1) | int'(hist[i]);
    return v;
  endfunction

  function automatic int minPat(input int n);
    return (n < PAT_W) ? n : PAT_W;
  endfunction

  // Reference update for one clock edge.
  function automatic void modelStep(input bit r, input bit c, input bit v, input bit b);
    int w;
    expMatch1 = 1'b0;
    expMatch0 = 1'b0;
    if (r || c) begin
      hist.delete();
      run1 = 0;
      run0 = 0;
      expCnt1 = 0;
      expCnt0 = 0;
    end else if (v) begin
      hist.push_back(b);
      if (hist.size() > PAT_W) void'(hist.pop_front());
      run1++;
      run0++;
      w = windowValue();
      if (run1 >= PAT_W && w == int'(PAT)) begin
        expMatch1 = 1'b1;
        if (expCnt1 < CNT_MAX) expCnt1++;
      end
      if (run0 >= PAT_W && w == int'(PAT)) begin
        expMatch0 = 1'b1;
        if (expCnt0 < CNT_MAX) expCnt0++;
        run0 = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
  endtask

  task automatic checkOutput();
    chk("match_ovl",  32'(match1), 32'(expMatch1));
    chk("cnt_ovl",    32'(cnt1),   32'(expCnt1));
    chk("win_ovl",    32'(win1),   32'(windowValue()));
    chk("fill_ovl",   32'(fill1),  32'(minPat(run1)));
    chk("match_novl", 32'(match0), 32'(expMatch0));
    chk("cnt_novl",   32'(cnt0),   32'(expCnt0));
    chk("win_novl",   32'(win0),   32'(windowValue()));
    chk("fill_novl",  32'(fill0),  32'(minPat(run0)));
  endtask

  // Drive one cycle of inputs, let the edge happen, then check just after.
  task automatic applyStimulus(input bit r, input bit c, input bit v, input bit b);
    rst = r; clr = c; bit_vld = v; bit_in = b;
    @(posedge clk);
    modelStep(r, c, v, b);
    #1;
    checkOutput();
  endtask

  task automatic sendBits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, bits[i]);
  endtask

  initial begin
    logic [15:0] gen;
    logic [7:0]  ovlStream;
    rst = 1'b1; clr = 1'b0; bit_vld = 1'b0; bit_in = 1'b0;

    // reset held with a valid 1 bit presented
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    chk("reset_cnt", 32'(cnt1), 32'd0);

    // generator stream 0x0D95 three times
    gen = 16'h0D95;
    for (int r = 0; r < 3; r++) sendBits(gen, 16);
    chk("gen_cnt_ovl", 32'(cnt1), 32'd3);

    // overlapping stream 1,0,1,1,0,1,1,0
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    ovlStream = 8'b1011_0110;
    sendBits({8'd0, ovlStream}, 8);
    chk("ovl_cnt_ovl",  32'(cnt1), 32'd2);
    chk("ovl_cnt_novl", 32'(cnt0), 32'd1);

    // gap without clr keeps the partial match
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    sendBits(16'b101, 3);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom));
    sendBits(16'b10, 2);
    chk("gap_match", 32'(match1), 32'd1);
    chk("gap_cnt",   32'(cnt1),   32'd1);

    // gap with clr loses it
    sendBits(16'b101, 3);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, (i == 4), 1'b0, 1'b0);
    sendBits(16'b10, 2);
    chk("gapclr_cnt", 32'(cnt1), 32'd0);

    // clr together with the completing bit
    sendBits(16'b1011, 4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    chk("clrbit_fill", 32'(fill1), 32'd0);
    chk("clrbit_match", 32'(match1), 32'd0);

    // saturation: 300 back-to-back patterns
    for (int i = 0; i < 300; i++) sendBits({11'd0, PAT}, PAT_W);
    chk("sat_cnt_ovl",  32'(cnt1), 32'd255);
    chk("sat_cnt_novl", 32'(cnt0), 32'd255);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // random bits, gaps, occasional clr and reset
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 499) == 0), ($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    // mid-pattern reset drops the partial match
    sendBits(16'b1011, 4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    sendBits(16'b0, 1);
    chk("rstmid_match", 32'(match1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
